// File: rtl/rom_programavel.sv
// rtl/rom_programavel.sv - writable instruction memory with registered fetch, program-load port and clear sweep
module rom_programavel #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic fetch_in_range, prog_in_range, fetch_accept;

  // Range checks use the full address width so high addresses never alias low words.
  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;
  assign prog_in_range  = {1'b0, prog_addr}  < DEPTH_X;

  assign busy         = (state == S_CLEAR);
  assign fetch_ready  = (state == S_READY) && (!instr_valid || instr_ready);
  assign fetch_accept = fetch_valid && fetch_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (cnt == LAST) state_next = S_READY;
      S_READY: state_next = S_READY;
      default: state_next = S_READY;
    endcase
  end

  // No reset on the array: contents must survive reset when the sweep is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_CLEAR) begin
        mem[cnt[IDX_W-1:0]] <= '0;
      end else if (prog_we && prog_in_range) begin
        mem[prog_addr[IDX_W-1:0]] <= prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_err   <= 1'b0;
      prog_ack    <= 1'b0;
    end else begin
      prog_ack <= (state == S_READY) && prog_we;
      if (state == S_CLEAR) begin
        cnt <= cnt + 1'b1;
      end
      // Read uses the pre-edge array value, so a same-cycle write returns old data.
      if (fetch_accept) begin
        instr_valid <= 1'b1;
        instr_err   <= !fetch_in_range;
        instr_out   <= fetch_in_range ? mem[fetch_addr[IDX_W-1:0]] : '0;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_programavel.sv
// tb/tb_rom_programavel.sv - directed bench: small cleared memory and large uncleared memory share stimulus
module tb_rom_programavel;

  logic       clk = 1'b0;
  logic       reset, fetch_valid, instr_ready, prog_we;
  logic [7:0] fetch_addr, prog_addr, prog_data;

  logic       a_busy, a_fetch_ready, a_instr_valid, a_instr_err, a_prog_ack;
  logic [7:0] a_instr_out;
  logic       b_busy, b_fetch_ready, b_instr_valid, b_instr_err, b_prog_ack;
  logic [7:0] b_instr_out;

  int checks = 0;
  int errors = 0;
  int n;
  logic bad;

  always #5 clk = ~clk;

  rom_programavel #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset), .busy(a_busy),
    .fetch_valid(fetch_valid), .fetch_ready(a_fetch_ready), .fetch_addr(fetch_addr),
    .instr_valid(a_instr_valid), .instr_ready(instr_ready), .instr_out(a_instr_out),
    .instr_err(a_instr_err), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_ack(a_prog_ack)
  );

  rom_programavel #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .reset(reset), .busy(b_busy),
    .fetch_valid(fetch_valid), .fetch_ready(b_fetch_ready), .fetch_addr(fetch_addr),
    .instr_valid(b_instr_valid), .instr_ready(instr_ready), .instr_out(b_instr_out),
    .instr_err(b_instr_err), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_ack(b_prog_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; fetch_valid = 1'b0; fetch_addr = 8'h00; instr_ready = 1'b1;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
    step();
    step();
    check("rst_a_busy",        32'(a_busy), 32'd1);
    check("rst_a_fetch_ready", 32'(a_fetch_ready), 32'd0);
    check("rst_a_valid",       32'(a_instr_valid), 32'd0);
    check("rst_a_out",         32'(a_instr_out), 32'h00);
    check("rst_a_err",         32'(a_instr_err), 32'd0);
    check("rst_a_ack",         32'(a_prog_ack), 32'd0);
    check("rst_b_busy",        32'(b_busy), 32'd0);
    check("rst_b_valid",       32'(b_instr_valid), 32'd0);

    // Clear sweep with a fetch pending the whole time
    reset = 1'b1; fetch_valid = 1'b1; fetch_addr = 8'h03;
    n = 0; bad = 1'b0;
    while (a_busy === 1'b1 && n < 40) begin
      if (a_fetch_ready !== 1'b0) bad = 1'b1;
      n++;
      step();
    end
    check("sweep_len", n, 32'd16);
    check("sweep_no_ready", 32'(bad), 32'd0);
    check("sweep_done_ready", 32'(a_fetch_ready), 32'd1);
    step();
    check("first_fetch_valid", 32'(a_instr_valid), 32'd1);
    check("first_fetch_out",   32'(a_instr_out), 32'h00);
    check("first_fetch_err",   32'(a_instr_err), 32'd0);
    fetch_valid = 1'b0;
    step();

    // Program load: acks one cycle after each strobe
    prog_we = 1'b1; prog_addr = 8'h00; prog_data = 8'h61;
    step();
    check("ack0", 32'(b_prog_ack), 32'd1);
    prog_addr = 8'h01; prog_data = 8'h69;
    step();
    check("ack1", 32'(b_prog_ack), 32'd1);
    prog_addr = 8'h02; prog_data = 8'h46;
    step();
    check("ack2", 32'(b_prog_ack), 32'd1);
    check("ack2_a", 32'(a_prog_ack), 32'd1);
    prog_we = 1'b0;
    step();
    check("ack_off", 32'(b_prog_ack), 32'd0);

    // Back-to-back fetch
    fetch_valid = 1'b1; fetch_addr = 8'h00;
    step();
    check("b2b_0", 32'(b_instr_out), 32'h61);
    check("b2b_0_valid", 32'(b_instr_valid), 32'd1);
    fetch_addr = 8'h01;
    step();
    check("b2b_1", 32'(b_instr_out), 32'h69);
    fetch_addr = 8'h02;
    step();
    check("b2b_2", 32'(b_instr_out), 32'h46);
    fetch_valid = 1'b0;
    step();
    check("drain_valid", 32'(b_instr_valid), 32'd0);
    check("drain_hold",  32'(b_instr_out), 32'h46);

    // Backpressure
    fetch_valid = 1'b1; fetch_addr = 8'h01;
    step();
    instr_ready = 1'b0; fetch_addr = 8'h02;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (b_fetch_ready !== 1'b0 || b_instr_valid !== 1'b1 || b_instr_out !== 8'h69) bad = 1'b1;
      step();
    end
    check("bp_stall", 32'(bad), 32'd0);
    instr_ready = 1'b1;
    step();
    check("bp_release_out",   32'(b_instr_out), 32'h46);
    check("bp_release_valid", 32'(b_instr_valid), 32'd1);
    fetch_valid = 1'b0;
    step();

    // Out of range on the 16-word instance
    fetch_valid = 1'b1; fetch_addr = 8'h15;
    step();
    check("oor_out",   32'(a_instr_out), 32'h00);
    check("oor_err",   32'(a_instr_err), 32'd1);
    check("oor_valid", 32'(a_instr_valid), 32'd1);
    fetch_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 8'h12; prog_data = 8'hAA;
    step();
    check("oor_ack", 32'(a_prog_ack), 32'd1);
    prog_we = 1'b0;
    fetch_valid = 1'b1; fetch_addr = 8'h02;
    step();
    check("no_alias_out", 32'(a_instr_out), 32'h46);
    check("no_alias_err", 32'(a_instr_err), 32'd0);
    fetch_valid = 1'b0;
    step();

    // Collision: read-before-write
    prog_we = 1'b1; prog_addr = 8'h07; prog_data = 8'h37;
    step();
    prog_data = 8'h75; fetch_valid = 1'b1; fetch_addr = 8'h07;
    step();
    check("coll_old_a", 32'(a_instr_out), 32'h37);
    check("coll_old_b", 32'(b_instr_out), 32'h37);
    prog_we = 1'b0;
    step();
    check("coll_new_a", 32'(a_instr_out), 32'h75);
    check("coll_new_b", 32'(b_instr_out), 32'h75);
    fetch_valid = 1'b0;
    step();

    // Reset with an instruction held valid
    fetch_valid = 1'b1; fetch_addr = 8'h15; instr_ready = 1'b0;
    step();
    check("pre_rst_a_err",   32'(a_instr_err), 32'd1);
    check("pre_rst_b_valid", 32'(b_instr_valid), 32'd1);
    fetch_valid = 1'b0; reset = 1'b0;
    step();
    check("mid_rst_a_valid", 32'(a_instr_valid), 32'd0);
    check("mid_rst_a_err",   32'(a_instr_err), 32'd0);
    check("mid_rst_b_valid", 32'(b_instr_valid), 32'd0);
    check("mid_rst_b_out",   32'(b_instr_out), 32'h00);
    check("mid_rst_a_busy",  32'(a_busy), 32'd1);
    check("mid_rst_b_busy",  32'(b_busy), 32'd0);

    // Reset again at cnt=9; sweep must restart from zero
    instr_ready = 1'b1; reset = 1'b1;
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    n = 0;
    while (a_busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("resweep_len", n, 32'd16);
    fetch_valid = 1'b1; fetch_addr = 8'h07;
    step();
    check("cleared_a7",  32'(a_instr_out), 32'h00);
    check("survive_b7",  32'(b_instr_out), 32'h75);
    fetch_addr = 8'h01;
    step();
    check("cleared_a1",  32'(a_instr_out), 32'h00);
    check("survive_b1",  32'(b_instr_out), 32'h69);
    fetch_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_programavel.md
Name: rom_programavel

Overview:
- Parametrised, writable instruction memory that replaces the fixed asynchronous-read program ROM ahead of the fetch stage.
- Adds a registered fetch path with valid/ready handshake and backpressure.
- Adds a program-load write port so the program can be loaded at run time.
- Adds a post-reset hardware clear sweep and out-of-range address detection.

Parameters:
- DATA_W, 8, instruction width in bits (opcode plus operand).
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents are kept across reset.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, synchronous, active-low reset.
- busy, output, 1, high while the clear sweep is running.
- fetch_valid, input, 1, fetch request present.
- fetch_ready, output, 1, block can accept a fetch this cycle.
- fetch_addr, input, ADDR_W, fetch address.
- instr_valid, output, 1, instr_out and instr_err are valid.
- instr_ready, input, 1, consumer accepts the instruction.
- instr_out, output, DATA_W, fetched instruction word.
- instr_err, output, 1, fetch address was >= DEPTH.
- prog_we, input, 1, program-load write strobe.
- prog_addr, input, ADDR_W, write address.
- prog_data, input, DATA_W, write data.
- prog_ack, output, 1, one-cycle pulse acknowledging a write strobe.

Behaviour:
- Reset (reset=0 at a clk edge), whichever state the block is in:
  - instr_valid=0, instr_out=0, instr_err=0, prog_ack=0, clear counter=0.
  - Next state is CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - busy=1 in CLEAR, 0 in READY.
- States:
  - CLEAR: each cycle writes 0 to mem[cnt], then cnt++. After writing word DEPTH-1, the next state is READY. The sweep takes exactly DEPTH cycles.
    - busy=1 and fetch_ready=0.
    - prog_we is ignored: no write and no prog_ack.
  - READY: busy=0. The block stays here until reset.
- Reset asserted mid-sweep restarts the sweep at address 0.
- Fetch handshake (READY only):
  - fetch_ready = !instr_valid || instr_ready, computed combinationally.
  - A fetch is accepted on an edge where fetch_valid && fetch_ready.
  - Latency is 1 cycle: at that edge instr_valid<=1 and instr_out<=mem[fetch_addr].
    - If fetch_addr >= DEPTH: instr_out<=0 and instr_err<=1; otherwise instr_err<=0.
  - If instr_valid && instr_ready and no new fetch is accepted: instr_valid<=0. instr_out and instr_err hold their last values.
  - If instr_valid && !instr_ready: instr_out, instr_err and instr_valid hold stable, and fetch_ready=0.
  - Back-to-back fetches with instr_ready held high give one instruction per cycle.
- Program load (READY only):
  - When prog_we=1 and prog_addr < DEPTH, mem[prog_addr]<=prog_data at that edge.
  - prog_ack=1 on the following cycle for every prog_we seen in READY, including out-of-range addresses. An out-of-range write is dropped.
  - Consecutive prog_we cycles produce consecutive ack pulses.
- Collision: a write and an accepted fetch to the same address in the same cycle return the OLD data (read-before-write). The new data is visible from the next fetch on.
- Memory width rules:
  - mem is DEPTH words of DATA_W bits.
  - Address compares are unsigned over the full ADDR_W. Upper address bits are never truncated to alias lower words.
- With CLEAR_ON_RESET=0, contents are undefined until written and are preserved across reset.
- No memory-file preload: the program is always loaded through prog_*.

Test Plan:
- Clear sweep, DEPTH=16, CLEAR_ON_RESET=1: release reset, then drive fetch_valid=1 constantly.
  - busy is high for exactly 16 cycles and fetch_ready stays 0 during that time.
  - The first fetch of addr 3 returns 0x00 with instr_err=0.
- Load and run, DATA_W=8, DEPTH=256: write 0x61, 0x69, 0x46 to addresses 0..2 on consecutive cycles.
  - prog_ack pulses on 3 consecutive cycles, each one cycle after its strobe.
  - Fetching 0, 1, 2 back-to-back with instr_ready=1 gives instr_out 0x61, 0x69, 0x46 on 3 consecutive cycles.
- Backpressure: fetch addr 1, then hold instr_ready=0 for 4 cycles with fetch_valid=1 and addr 2.
  - instr_out stays 0x69 with valid=1 and fetch_ready=0 for the 4 cycles.
  - After instr_ready rises, 0x46 appears on the next cycle.
- Out of range, DEPTH=16, ADDR_W=8:
  - Fetching addr 0x15 gives instr_out=0x00 and instr_err=1.
  - Writing 0xAA to addr 0x12 produces a prog_ack pulse, and a later fetch of addr 0x02 still returns its old value.
- Collision: mem[7]=0x37; in the same cycle write 0x75 to addr 7 and accept a fetch of addr 7.
  - That fetch returns 0x37.
  - The next fetch of addr 7 returns 0x75.
- Reset mid-operation: assert reset during the clear sweep (cnt=9) and again with instr_valid=1.
  - The sweep restarts at address 0 and takes the full DEPTH cycles.
  - instr_valid=0 and instr_out=0 on the cycle after reset.
  - With CLEAR_ON_RESET=0, previously loaded data survives the reset.
